// File: rtl/gate_op_pkg.sv
// Shared opcode encodings, opcode width and FSM state type for gate_op_arbiter.
package gate_op_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND     = 3'd0;
    localparam logic [OP_W-1:0] OP_OR      = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND    = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR     = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR     = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR    = 3'd5;
    localparam logic [OP_W-1:0] OP_NOT     = 3'd6;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gate_rr_arbiter.sv
// Combinational round-robin grant: searches from last_grant_i+1 upward with wrap,
// producing a one-hot grant and its encoded index. No grant when en_i is low.
module gate_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    logic [ID_W:0] cand;
    logic          found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        // One extra bit of headroom so last_grant + offset never overflows before the wrap.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_i} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (en_i && !found && req_i[cand[ID_W-1:0]]) begin
                found                      = 1'b1;
                grant_o[cand[ID_W-1:0]]    = 1'b1;
                grant_idx_o                = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin shared bitwise logic unit: IDLE (grant/accept) -> EXEC (compute) -> RESP (hold result).
// Optional per-requester accept counters are built when GATE_OP_ARBITER_STATS_EN is defined.
module gate_op_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int W       = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [3*NUM_REQ-1:0] req_op,
    input  logic [W*NUM_REQ-1:0] req_a,
    input  logic [W*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [W-1:0]         rsp_data,
`ifdef GATE_OP_ARBITER_STATS_EN
    output logic                 rsp_err,
    input  logic                 stats_clr,
    output logic [16*NUM_REQ-1:0] grant_count
`else
    output logic                 rsp_err
`endif
);

    import gate_op_pkg::*;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_grant_q;
    logic [OP_W-1:0]     op_q;
    logic [W-1:0]        a_q, b_q;
    logic [ID_W-1:0]     id_q;
    logic [W-1:0]        rsp_data_q;
    logic                rsp_err_q;
    logic [ID_W-1:0]     rsp_id_q;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                arb_en;
    logic                accept;
    logic [W-1:0]        res_data;
    logic                res_err;

    logic [OP_W-1:0]     op_arr [NUM_REQ];
    logic [W-1:0]        a_arr  [NUM_REQ];
    logic [W-1:0]        b_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op_arr[gi] = req_op[gi*OP_W +: OP_W];
        assign a_arr[gi]  = req_a[gi*W +: W];
        assign b_arr[gi]  = req_b[gi*W +: W];
    end

    // Grant is suppressed during reset so req_ready reads 0 whatever the stale state.
    assign arb_en = (state_q == IDLE) && !rst;

    gate_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .en_i         (arb_en),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = grant;
        accept    = |(req_valid & grant);
        rsp_valid = (state_q == RESP) && !rst;
    end

    always_comb begin
        res_data = '0;
        res_err  = 1'b0;
        case (op_q)
            OP_AND:     res_data = a_q & b_q;
            OP_OR:      res_data = a_q | b_q;
            OP_NAND:    res_data = ~(a_q & b_q);
            OP_NOR:     res_data = ~(a_q | b_q);
            OP_XOR:     res_data = a_q ^ b_q;
            OP_XNOR:    res_data = ~(a_q ^ b_q);
            OP_NOT:     res_data = ~a_q;
            OP_ILLEGAL: res_err  = 1'b1;
            default:    res_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            if (accept) begin
                op_q         <= op_arr[grant_idx];
                a_q          <= a_arr[grant_idx];
                b_q          <= b_arr[grant_idx];
                id_q         <= grant_idx;
                last_grant_q <= grant_idx;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= res_data;
                rsp_err_q  <= res_err;
                rsp_id_q   <= id_q;
            end
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_id   = rsp_id_q;

`ifdef GATE_OP_ARBITER_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        // A clear that coincides with an accept wins.
        always_ff @(posedge clk) begin
            if (rst || stats_clr) begin
                cnt_q[gi] <= '0;
            end else if (accept && (grant_idx == ID_W'(gi)) && (cnt_q[gi] != 16'hFFFF)) begin
                cnt_q[gi] <= cnt_q[gi] + 16'd1;
            end
        end
        assign grant_count[gi*16 +: 16] = cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Self-checking bench for gate_op_arbiter: directed steps, scoreboard of expected responses.
// Exercises the stats counters when GATE_OP_ARBITER_STATS_EN is defined.
module tb_gate_op_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [3*N-1:0]   req_op;
    logic [W*N-1:0]   req_a;
    logic [W*N-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
`ifdef GATE_OP_ARBITER_STATS_EN
    logic             stats_clr;
    logic [16*N-1:0]  grant_count;
`endif

    gate_op_arbiter #(.NUM_REQ(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
`ifdef GATE_OP_ARBITER_STATS_EN
        .rsp_err     (rsp_err),
        .stats_clr   (stats_clr),
        .grant_count (grant_count)
`else
        .rsp_err     (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
        logic           err;
    } rsp_t;

    rsp_t sb[$];
    int   acc_g[$];
    int   acc_t[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_state = 0;    // 0 idle, 1 exec, 2 resp
    int   m_last  = N-1;
    int   cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t model(input int id, input logic [2:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        rsp_t r;
        r.id   = IDW'(id);
        r.err  = 1'b0;
        r.data = '0;
        case (op)
            3'd0: r.data = a & b;
            3'd1: r.data = a | b;
            3'd2: r.data = ~(a & b);
            3'd3: r.data = ~(a | b);
            3'd4: r.data = a ^ b;
            3'd5: r.data = ~(a ^ b);
            3'd6: r.data = ~a;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]     = v;
        req_op[3*i +: 3] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    // One clock: check outputs against the model, advance the model, cross the edge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int g;
        int idx;
        rsp_t r;
        #1;
        exp_rdy = '0;
        g = -1;
        if (!rst && m_state == 0) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(!rst && m_state == 2));
        if (!rst && m_state == 2 && sb.size() > 0) begin
            r = sb[0];
            chk("rsp_id",   32'(rsp_id),   32'(r.id));
            chk("rsp_data", 32'(rsp_data), 32'(r.data));
            chk("rsp_err",  32'(rsp_err),  32'(r.err));
        end
        if (rst) begin
            m_state = 0;
            m_last  = N-1;
            sb.delete();
        end else begin
            case (m_state)
                0: if (g >= 0) begin
                    sb.push_back(model(g, req_op[3*g +: 3], req_a[W*g +: W], req_b[W*g +: W]));
                    acc_g.push_back(g);
                    acc_t.push_back(cyc);
                    m_last  = g;
                    m_state = 1;
                end
                1: m_state = 2;
                default: if (rsp_ready) begin
                    r = sb.pop_front();
                    $display("rsp id=%0d data=%h err=%b", r.id, r.data, r.err);
                    m_state = 0;
                end
            endcase
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((m_state != 0 || sb.size() != 0) && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int exp_rr [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
`ifdef GATE_OP_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif
        do_reset();
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_id",   32'(rsp_id),   32'd0);
        chk("reset_rsp_err",  32'(rsp_err),  32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);

        // No requests: stay idle.
        for (int i = 0; i < 4; i++) step();

        // Single AND request from req0.
        set_req(0, 1'b1, 3'd0, 8'hF0, 8'h3C);
        step();
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        chk("lat_exec_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("and_valid", 32'(rsp_valid), 32'd1);
        chk("and_data",  32'(rsp_data),  32'h30);
        chk("and_id",    32'(rsp_id),    32'd0);
        chk("and_err",   32'(rsp_err),   32'd0);
        rsp_ready = 1'b1;
        drain(10);

        // NOT from req2.
        set_req(2, 1'b1, 3'd6, 8'hA5, 8'hFF);
        step();
        set_req(2, 1'b0, 3'd0, 8'h00, 8'h00);
        step();
        chk("not_data", 32'(rsp_data), 32'h5A);
        chk("not_id",   32'(rsp_id),   32'd2);
        chk("not_err",  32'(rsp_err),  32'd0);
        drain(10);

        // Illegal opcode from req1.
        set_req(1, 1'b1, 3'd7, 8'hFF, 8'hFF);
        step();
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        step();
        chk("ill_data", 32'(rsp_data), 32'h00);
        chk("ill_err",  32'(rsp_err),  32'd1);
        chk("ill_id",   32'(rsp_id),   32'd1);
        drain(10);

        // All four requesters valid continuously after reset.
        do_reset();
        acc_g.delete();
        acc_t.delete();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(i + 1), 8'(8'h11 * (i + 1)), 8'h5C);
        for (int i = 0; i < 18; i++) step();
        req_valid = '0;
        drain(10);
        chk("rr_count", 32'(acc_g.size()), 32'd6);
        if (acc_g.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("rr_order", 32'(acc_g[i]), 32'(exp_rr[i]));
            for (int i = 1; i < 6; i++) chk("rr_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'd3);
        end

        // Backpressure: hold result 5 cycles with another requester waiting.
        rsp_ready = 1'b0;
        set_req(3, 1'b1, 3'd4, 8'h5A, 8'hFF);
        step();
        set_req(3, 1'b0, 3'd0, 8'h00, 8'h00);
        set_req(1, 1'b1, 3'd1, 8'h0F, 8'h30);
        step();
        chk("bp_data_first", 32'(rsp_data), 32'hA5);
        for (int i = 0; i < 5; i++) step();
        chk("bp_data_last", 32'(rsp_data), 32'hA5);
        chk("bp_id_last",   32'(rsp_id),   32'd3);
        rsp_ready = 1'b1;
        step();
        #1;
        chk("bp_idle_reentry", 32'(req_ready), 32'b0010);
        step();
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        drain(10);

        // Reset while req3 is in EXEC: response discarded, req0 gets first priority.
        set_req(3, 1'b1, 3'd0, 8'hFF, 8'h0F);
        step();
        set_req(3, 1'b0, 3'd0, 8'h00, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 4; i++) step();
        set_req(0, 1'b1, 3'd1, 8'h01, 8'h02);
        set_req(3, 1'b1, 3'd2, 8'hFF, 8'hFF);
        #1;
        chk("post_rst_prio", 32'(req_ready), 32'b0001);
        step();
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        drain(10);
        step();
        set_req(3, 1'b0, 3'd0, 8'h00, 8'h00);
        drain(10);

`ifdef GATE_OP_ARBITER_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(1, 1'b1, 3'd0, 8'hAA, 8'h55);
            step();
            set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
            drain(10);
        end
        chk("stats_req1", 32'(grant_count[16 +: 16]), 32'd3);
        chk("stats_req0", 32'(grant_count[0 +: 16]),  32'd0);
        set_req(1, 1'b1, 3'd0, 8'hAA, 8'h55);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        chk("stats_clr_accept", 32'(grant_count[16 +: 16]), 32'd0);
        drain(10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gate_op_arbiter.md
Name: gate_op_arbiter

Overview:
- Shares one registered bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR/NOT) among NUM_REQ requesters.
- Each requester submits an opcode and two operands over a valid/ready handshake.
- The block arbitrates round-robin, executes one operation at a time, and returns the tagged result on a single response channel with backpressure.
- Sits between the requesting client blocks and the shared gate datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- W, 8, operand/result width in bits.
- ID_W, $clog2(NUM_REQ), derived; width of rsp_id. Not to be overridden.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_op  input  3*NUM_REQ  opcode, slice i = [3*i+2:3*i].
- req_a  input  W*NUM_REQ  operand A, slice i.
- req_b  input  W*NUM_REQ  operand B, slice i (ignored for NOT).
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  index of requester that owns the result.
- rsp_data  output  W  result.
- rsp_err  output  1  opcode was illegal.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Opcodes:
  - 0 = AND, 1 = OR, 2 = NAND, 3 = NOR, 4 = XOR, 5 = XNOR, 6 = NOT (~a).
  - 7 = illegal: rsp_data = 0, rsp_err = 1.
  - All ops are bitwise over W bits.
- FSM states:
  - IDLE → EXEC on accept.
  - EXEC → RESP unconditionally.
  - RESP → IDLE when rsp_valid & rsp_ready.
- IDLE:
  - Round-robin grant is computed combinationally from req_valid, searching from last_grant+1 with wrap to 0.
  - req_ready[g] is high for the granted requester only; in all other states req_ready = 0.
  - On accept (req_valid[g] & req_ready[g]): latch op, a, b and g; update last_grant = g.
- EXEC: compute the result and register it into rsp_data/rsp_err/rsp_id.
- RESP:
  - rsp_valid = 1.
  - rsp_data, rsp_id and rsp_err are held stable until the handshake.
- Latency and throughput:
  - Accept edge to rsp_valid high is 2 cycles.
  - Peak throughput is one op per 3 cycles.
- Requester protocol:
  - A requester may drop req_valid before acceptance; the grant is re-evaluated every IDLE cycle.
  - Operands are sampled only at the accept edge.
- Reset values:
  - State = IDLE, last_grant = NUM_REQ-1 (requester 0 has first priority).
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0, req_ready = 0 during reset.
- Reset mid-operation: any state goes to IDLE on the next edge; the in-flight op is discarded without a response.
- No requests: remain in IDLE, last_grant unchanged.
- Single persistent requester: granted every IDLE visit; no starvation of others once they assert valid.
- rsp_ready high while not in RESP: ignored.

Optional Feature:
- Macro: GATE_OP_ARBITER_STATS_EN.
- When defined:
  - Adds output grant_count, 16*NUM_REQ bits; slice i counts accepts of requester i.
  - Counters saturate at 16'hFFFF and clear on rst.
  - Adds input stats_clr (1 bit), which synchronously zeroes all counters. If an accept coincides with stats_clr, the counter becomes 0.
- When undefined: no counter logic and no extra ports; behaviour is otherwise identical.

Decomposition:
- Package gate_op_pkg holds:
  - opcode localparams OP_AND..OP_NOT and OP_ILLEGAL;
  - the FSM state enum (IDLE/EXEC/RESP);
  - the opcode width constant (3).
- Sub-module gate_rr_arbiter:
  - Inputs: NUM_REQ-wide request vector, last_grant pointer, and an enable (high in IDLE).
  - Outputs: one-hot grant and encoded grant index.
  - Purely combinational.
- The bitwise op evaluation stays inline in the top.

Test Plan:
- Single request: req0 op=0 (AND), a=8'hF0, b=8'h3C → accepted, then 2 cycles later rsp_valid=1, rsp_data=8'h30, rsp_id=0, rsp_err=0.
- All four requesters valid continuously after reset, rsp_ready=1 → grant order 0,1,2,3,0,1; each accept 3 cycles apart.
- NOT from req2, a=8'hA5, b=8'hFF → rsp_data=8'h5A, rsp_id=2. Opcode 7 from req1 → rsp_data=8'h00, rsp_err=1.
- Backpressure: rsp_ready held low 5 cycles in RESP → rsp_valid, rsp_data and rsp_id stable; req_ready=0 throughout; IDLE is re-entered the cycle after rsp_ready rises.
- Reset asserted in EXEC with req3 in flight → next cycle rsp_valid=0 and no response for req3 ever appears. With req0 and req3 then valid, req0 is granted first.
- With GATE_OP_ARBITER_STATS_EN: 3 accepts from req1 → grant_count slice 1 = 3. stats_clr coinciding with an accept → slice = 0.
